// File: rtl/mem_pkg.sv
// Shared types for the load/store sequencer: operation codes, data_mem
// byte-access codes and the sequencer state encoding.
package mem_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        BA_NONE = 2'b00,
        BA_RDB  = 2'b01,
        BA_WRB  = 2'b10
    } ba_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC0,
        S_ACC1,
        S_RESP
    } state_e;

    // Access size minus one, used for the last-byte range check.
    function automatic logic [1:0] op_size_m1(input op_e op);
        case (op)
            OP_LW, OP_SW:         return 2'd3;
            OP_LH, OP_LHU, OP_SH: return 2'd1;
            default:              return 2'd0;
        endcase
    endfunction

    function automatic logic op_is_word(input op_e op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic op_is_half(input op_e op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load result formatting: selects and sign/zero-extends the captured data.
module load_extend
    import mem_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_data,
    output logic [31:0] o_rdata
);

    always_comb begin
        o_rdata = '0;
        case (op_e'(i_op))
            OP_LW:   o_rdata = i_data;
            OP_LH:   o_rdata = {{16{i_data[15]}}, i_data[15:0]};
            OP_LHU:  o_rdata = {16'h0000, i_data[15:0]};
            OP_LB:   o_rdata = {{24{i_data[7]}}, i_data[7:0]};
            OP_LBU:  o_rdata = {24'h000000, i_data[7:0]};
            default: o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer: splits word accesses into two big-endian halfword
// accesses to data_mem and returns an extended, registered load result.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int MEM_BYTES = 20,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_write,
    output logic              mem_read,
    output logic [1:0]        mem_byteaccess,
    output logic [ADDR_W-1:0] mem_address,
    output logic [15:0]       mem_data_in,
    input  logic [15:0]       mem_data_out,
    input  logic [7:0]        mem_data_out_byte
);

    state_e            r_state;
    state_e            w_next;
    op_e               r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_cap;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [31:0]       r_resp_rdata;

    op_e               w_req_op;
    logic [ADDR_W:0]   w_last;
    logic              w_misalign;
    logic              w_oob;
    logic              w_req_err;
    logic [31:0]       w_cap_next;
    logic [31:0]       w_ext;

    // One extra address bit so a request wrapping past 2^ADDR_W is out of range.
    assign w_req_op   = op_e'(req_op);
    assign w_last     = {1'b0, req_addr} + {{(ADDR_W-1){1'b0}}, op_size_m1(w_req_op)};
    assign w_oob      = w_last >= (ADDR_W+1)'(MEM_BYTES);
    assign w_misalign = (op_is_word(w_req_op) && (req_addr[1:0] != 2'b00)) ||
                        (op_is_half(w_req_op) && req_addr[0]);
    assign w_req_err  = w_misalign || w_oob;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        req_ready      = 1'b0;
        mem_write      = 1'b0;
        mem_read       = 1'b0;
        mem_byteaccess = BA_NONE;
        mem_address    = '0;
        mem_data_in    = '0;
        w_cap_next     = r_cap;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next = w_req_err ? S_RESP : S_ACC0;
                end
            end
            S_ACC0: begin
                mem_address = r_addr;
                case (r_op)
                    OP_LW: begin
                        mem_read          = 1'b1;
                        w_cap_next[31:16] = mem_data_out;
                    end
                    OP_LH, OP_LHU: begin
                        mem_read         = 1'b1;
                        w_cap_next[15:0] = mem_data_out;
                    end
                    OP_LB, OP_LBU: begin
                        mem_byteaccess   = BA_RDB;
                        w_cap_next[15:0] = {8'h00, mem_data_out_byte};
                    end
                    OP_SW: begin
                        mem_write   = 1'b1;
                        mem_data_in = r_wdata[31:16];
                    end
                    OP_SH: begin
                        mem_write   = 1'b1;
                        mem_data_in = r_wdata[15:0];
                    end
                    default: begin
                        mem_byteaccess = BA_WRB;
                        mem_data_in    = {8'h00, r_wdata[7:0]};
                    end
                endcase
                w_next = op_is_word(r_op) ? S_ACC1 : S_RESP;
            end
            S_ACC1: begin
                mem_address = r_addr + ADDR_W'(2);
                if (r_op == OP_LW) begin
                    mem_read         = 1'b1;
                    w_cap_next[15:0] = mem_data_out;
                end else begin
                    mem_write   = 1'b1;
                    mem_data_in = r_wdata[15:0];
                end
                w_next = S_RESP;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        // Strobes are masked during reset so an aborted word store loses its second half.
        if (rst) begin
            mem_write      = 1'b0;
            mem_read       = 1'b0;
            mem_byteaccess = BA_NONE;
        end
    end

    // Extension sees the halfword being captured this cycle, so the result registers in step with RESP.
    load_extend u_load_extend (
        .i_op    (r_op),
        .i_data  (w_cap_next),
        .o_rdata (w_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cap        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_cap        <= w_cap_next;
            r_resp_valid <= (w_next == S_RESP);
            r_resp_err   <= (r_state == S_IDLE) && (w_next == S_RESP);
            r_resp_rdata <= ((w_next == S_RESP) && (r_state != S_IDLE)) ? w_ext : '0;
            if ((r_state == S_IDLE) && req_valid) begin
                r_op    <= w_req_op;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural data_mem model.
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int MEM_BYTES = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_write;
    logic        mem_read;
    logic [1:0]  mem_byteaccess;
    logic [31:0] mem_address;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;
    logic [7:0]  mem_data_out_byte;

    logic        load_mem;
    logic [7:0]  mem     [0:MEM_BYTES-1];
    logic [7:0]  ref_mem [0:MEM_BYTES-1];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
        string       tag;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int          kind;
        logic [31:0] addr;
    } strobe_t;
    strobe_t slog[$];

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_BYTES(MEM_BYTES), .ADDR_W(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_op            (req_op),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .resp_valid        (resp_valid),
        .resp_rdata        (resp_rdata),
        .resp_err          (resp_err),
        .mem_write         (mem_write),
        .mem_read          (mem_read),
        .mem_byteaccess    (mem_byteaccess),
        .mem_address       (mem_address),
        .mem_data_in       (mem_data_in),
        .mem_data_out      (mem_data_out),
        .mem_data_out_byte (mem_data_out_byte)
    );

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            4:       return 8'h13;
            5:       return 8'h42;
            6:       return 8'hAD;
            7:       return 8'hDE;
            default: return 8'(i * 37 + 11);
        endcase
    endfunction

    // data_mem stand-in: combinational reads, clocked writes
    always_comb begin
        mem_data_out      = (mem_address < 32'(MEM_BYTES - 1)) ?
                            {mem[mem_address[4:0]], mem[mem_address[4:0] + 5'd1]} : 16'h0000;
        mem_data_out_byte = (mem_address < 32'(MEM_BYTES)) ? mem[mem_address[4:0]] : 8'h00;
    end

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < MEM_BYTES; i++) mem[i] <= init_byte(i);
        end else begin
            if (mem_write && (mem_address < 32'(MEM_BYTES - 1))) begin
                mem[mem_address[4:0]]        <= mem_data_in[15:8];
                mem[mem_address[4:0] + 5'd1] <= mem_data_in[7:0];
            end
            if ((mem_byteaccess == 2'b10) && (mem_address < 32'(MEM_BYTES)))
                mem[mem_address[4:0]] <= mem_data_in[7:0];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int ns;
        ns = int'(mem_read) + int'(mem_write) + int'(mem_byteaccess != 2'b00);
        if (ns != 0) begin
            check_val("strobe_onehot", 32'(ns), 32'd1);
            check_val("strobe_not_idle", 32'(req_ready), 32'd0);
            slog.push_back('{kind: (mem_read ? 1 : mem_write ? 2 : 3), addr: mem_address});
        end
    end

    // Reference behaviour: error/latency rules plus big-endian byte model.
    function automatic void model(input logic [2:0] op, input logic [31:0] addr,
                                  input logic [31:0] wd, output exp_t e);
        int          size;
        int          a;
        logic [63:0] last;
        logic [15:0] h;
        size = (op == OP_LW || op == OP_SW) ? 4 :
               (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2 : 1;
        last = {32'h0, addr} + 64'(size - 1);
        e.rd  = 32'h0;
        e.err = ((size == 4) && (addr[1:0] != 2'b00)) || ((size == 2) && addr[0]) ||
                (last >= 64'(MEM_BYTES));
        e.lat = e.err ? 1 : (size == 4) ? 3 : 2;
        if (!e.err) begin
            a = int'(addr);
            h = {ref_mem[a], ref_mem[(size > 1) ? a + 1 : a]};
            case (op)
                OP_LW:  e.rd = {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
                OP_LH:  e.rd = {{16{h[15]}}, h};
                OP_LHU: e.rd = {16'h0, h};
                OP_LB:  e.rd = {{24{ref_mem[a][7]}}, ref_mem[a]};
                OP_LBU: e.rd = {24'h0, ref_mem[a]};
                OP_SW:  begin
                    ref_mem[a]   = wd[31:24]; ref_mem[a+1] = wd[23:16];
                    ref_mem[a+2] = wd[15:8];  ref_mem[a+3] = wd[7:0];
                end
                OP_SH:  begin ref_mem[a] = wd[15:8]; ref_mem[a+1] = wd[7:0]; end
                default: ref_mem[a] = wd[7:0];
            endcase
        end
    endfunction

    task automatic send(input string tag, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wd);
        exp_t e;
        @(negedge clk);
        check_val({tag, "_ready"}, 32'(req_ready), 32'd1);
        model(op, addr, wd, e);
        e.tag = tag;
        sb.push_back(e);
        req_op = op; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_resp();
        exp_t e;
        int   n;
        bit   seen;
        if (sb.size() == 0) begin
            check_val("sb_nonempty", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        n = 0;
        seen = 1'b0;
        while (!seen && n < 8) begin
            @(negedge clk);
            n++;
            if (resp_valid) seen = 1'b1;
        end
        check_val({e.tag, "_valid"}, 32'(seen), 32'd1);
        check_val({e.tag, "_lat"}, 32'(n), 32'(e.lat));
        check_val({e.tag, "_rdata"}, resp_rdata, e.rd);
        check_val({e.tag, "_err"}, 32'(resp_err), 32'(e.err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  ld_op   [4] = '{OP_LB, OP_LBU, OP_LH, OP_LHU};
        logic [31:0] ld_addr [4] = '{32'd6, 32'd6, 32'd6, 32'd4};
        logic [2:0]  er_op   [6] = '{OP_LW, OP_SH, OP_LW, OP_LB, OP_LW, OP_LB};
        logic [31:0] er_addr [6] = '{32'd5, 32'd3, 32'd18, 32'd20, 32'hFFFF_FFFC, 32'hFFFF_FFFF};
        exp_t e;

        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = init_byte(i);
        rst = 1'b1; load_mem = 1'b1; req_valid = 1'b0;
        req_op = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_ready", 32'(req_ready), 32'd1);
        check_val("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_val("rst_resp_err", 32'(resp_err), 32'd0);
        check_val("rst_resp_rdata", resp_rdata, 32'd0);
        check_val("rst_strobes", {29'd0, mem_read, mem_write, |mem_byteaccess}, 32'd0);
        rst = 1'b0; load_mem = 1'b0;

        slog.delete();
        send("lw4", OP_LW, 32'd4, 32'd0);
        wait_resp();
        check_val("lw4_nstrobe", 32'(slog.size()), 32'd2);
        if (slog.size() >= 2) begin
            check_val("lw4_rd0_kind", 32'(slog[0].kind), 32'd1);
            check_val("lw4_rd0_addr", slog[0].addr, 32'd4);
            check_val("lw4_rd1_kind", 32'(slog[1].kind), 32'd1);
            check_val("lw4_rd1_addr", slog[1].addr, 32'd6);
        end

        for (int i = 0; i < 4; i++) begin
            send($sformatf("ld%0d", i), ld_op[i], ld_addr[i], 32'd0);
            wait_resp();
        end

        send("sw16", OP_SW, 32'd16, 32'hCAFE_F00D);   wait_resp();
        send("lw16", OP_LW, 32'd16, 32'd0);           wait_resp();
        send("sb14", OP_SB, 32'd14, 32'h0000_005A);   wait_resp();
        send("lbu14", OP_LBU, 32'd14, 32'd0);         wait_resp();
        send("lh18", OP_LH, 32'd18, 32'd0);           wait_resp();
        send("lb19", OP_LB, 32'd19, 32'd0);           wait_resp();

        for (int i = 0; i < 6; i++) begin
            slog.delete();
            send($sformatf("err%0d", i), er_op[i], er_addr[i], 32'hFFFF_FFFF);
            wait_resp();
            check_val($sformatf("err%0d_nostrobe", i), 32'(slog.size()), 32'd0);
        end

        // back-to-back: second request held valid throughout the first
        @(negedge clk);
        check_val("b2b_ready0", 32'(req_ready), 32'd1);
        model(OP_LW, 32'd8, 32'd0, e); e.tag = "b2b_lw8"; sb.push_back(e);
        req_op = OP_LW; req_addr = 32'd8; req_valid = 1'b1;
        @(posedge clk);
        #1;
        model(OP_LBU, 32'd6, 32'd0, e); e.tag = "b2b_lbu6"; sb.push_back(e);
        req_op = OP_LBU; req_addr = 32'd6;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check_val($sformatf("b2b_busy_c%0d", c), 32'(req_ready), 32'd0);
        end
        e = sb.pop_front();
        check_val("b2b_lw8_valid", 32'(resp_valid), 32'd1);
        check_val("b2b_lw8_rdata", resp_rdata, e.rd);
        @(negedge clk);
        check_val("b2b_second_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_resp();

        // reset during the second half of a word store
        @(negedge clk);
        check_val("rsw_ready", 32'(req_ready), 32'd1);
        req_op = OP_SW; req_addr = 32'd8; req_wdata = 32'h1122_3344; req_valid = 1'b1;
        ref_mem[8] = 8'h11; ref_mem[9] = 8'h22;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("rsw_acc1_write", 32'(mem_write), 32'd1);
        check_val("rsw_acc1_addr", mem_address, 32'd10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("rsw_ready_after", 32'(req_ready), 32'd1);
        for (int c = 0; c < 3; c++) begin
            check_val($sformatf("rsw_no_resp%0d", c), 32'(resp_valid), 32'd0);
            @(negedge clk);
        end
        check_val("rsw_byte10", 32'(mem[10]), 32'(ref_mem[10]));
        check_val("rsw_byte11", 32'(mem[11]), 32'(ref_mem[11]));
        send("rsw_lw8", OP_LW, 32'd8, 32'd0);
        wait_resp();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
